md_iter: RTL

//  Parametrised multiply/divide unit for the E stage of the pipelined CPU. It is the successor to the

---
 rtl/md_iter_if.sv | 26 ++
 rtl/md_iter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/md_iter_if.sv
// Bus between the pipeline E stage and the md_iter multiply/divide unit.
// The pipeline side drives operands, opcode and the cancel controls; the unit
// returns busy, the invalid pulse and the architectural HI/LO registers.
interface md_iter_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] dh;
    logic [WIDTH-1:0] dl;
    logic [3:0]       op;
    logic             stop;
    logic             restore;
    logic             busy;
    logic             invalid;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output dh, dl, op, stop, restore,
        input  busy, invalid, hi, lo
    );

    modport slave (
        input  dh, dl, op, stop, restore,
        output busy, invalid, hi, lo
    );
endinterface

// File: rtl/md_iter.sv
// md_iter: parametrised multiply/divide unit holding HI/LO.
// Multi-cycle ops keep busy high for a fixed number of cycles and write HI/LO
// on the edge where busy falls. A snapshot of {HI,LO} taken at every accepted
// op allows a rollback (restore) on exceptions.
// Optional feature: define MD_ITER_MAC_EN to enable MADD/MADDU/MSUB/MSUBU
// (ops 7-10); without it those opcodes are rejected as undefined.
module md_iter #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input logic     clk,
    input logic     rst,
    md_iter_if.slave bus
);

    localparam logic [3:0] OpNop   = 4'd0;
    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;
`ifdef MD_ITER_MAC_EN
    localparam logic [3:0] OpMadd  = 4'd7;
    localparam logic [3:0] OpMaddu = 4'd8;
    localparam logic [3:0] OpMsub  = 4'd9;
    localparam logic [3:0] OpMsubu = 4'd10;
`endif

    localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]    hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0]  snap_q, snap_d;
    logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
    logic [3:0]          op_q, op_d;
    logic                invalid_q, invalid_d;

    logic                op_legal;
    logic                busy;
    logic [2*WIDTH-1:0]  prod_u, prod_s;
    logic [WIDTH-1:0]    a_mag, b_mag, divisor_s, divisor_u;
    logic [WIDTH-1:0]    quo_mag, rem_mag, quo_s, rem_s, quo_u, rem_u;
    logic [2*WIDTH-1:0]  res;

    assign busy = (state_q != StIdle);

    // Decode which opcodes exist in this build.
    always_comb begin
        op_legal = 1'b0;
        case (bus.op)
            OpMult, OpMultu, OpDiv, OpDivu, OpMthi, OpMtlo: op_legal = 1'b1;
`ifdef MD_ITER_MAC_EN
            OpMadd, OpMaddu, OpMsub, OpMsubu:               op_legal = 1'b1;
`endif
            default:                                        op_legal = 1'b0;
        endcase
    end

    // Arithmetic on the latched operands; consumed only at completion.
    always_comb begin
        // Sign-extending then multiplying unsigned yields the correct low 2*WIDTH bits.
        prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};

        // Signed divide via magnitudes; most-negative / -1 wraps back to most-negative.
        a_mag     = a_q[WIDTH-1] ? (~a_q + WIDTH'(1)) : a_q;
        b_mag     = b_q[WIDTH-1] ? (~b_q + WIDTH'(1)) : b_q;
        divisor_s = (b_mag == '0) ? WIDTH'(1) : b_mag;
        divisor_u = (b_q == '0) ? WIDTH'(1) : b_q;
        quo_mag   = a_mag / divisor_s;
        rem_mag   = a_mag % divisor_s;
        quo_s     = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? (~quo_mag + WIDTH'(1)) : quo_mag;
        rem_s     = a_q[WIDTH-1] ? (~rem_mag + WIDTH'(1)) : rem_mag;
        quo_u     = a_q / divisor_u;
        rem_u     = a_q % divisor_u;

        res = {hi_q, lo_q};
        case (op_q)
            OpMult:  res = prod_s;
            OpMultu: res = prod_u;
            OpDiv:   if (b_q != '0) res = {rem_s, quo_s};
            OpDivu:  if (b_q != '0) res = {rem_u, quo_u};
`ifdef MD_ITER_MAC_EN
            OpMadd:  res = {hi_q, lo_q} + prod_s;
            OpMaddu: res = {hi_q, lo_q} + prod_u;
            OpMsub:  res = {hi_q, lo_q} - prod_s;
            OpMsubu: res = {hi_q, lo_q} - prod_u;
`endif
            default: res = {hi_q, lo_q};
        endcase
    end

    // Next state: restore > stop > completion > accept.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        snap_d    = snap_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        invalid_d = (bus.op != OpNop) && (busy || !op_legal);

        if (bus.restore) begin
            {hi_d, lo_d} = snap_q;
            state_d      = StIdle;
            cnt_d        = '0;
        end else if (bus.stop) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (busy) begin
            if (cnt_q == CntW'(1)) begin
                {hi_d, lo_d} = res;
                state_d      = StIdle;
                cnt_d        = '0;
            end else begin
                cnt_d = cnt_q - CntW'(1);
            end
        end else if (bus.op != OpNop && op_legal) begin
            snap_d = {hi_q, lo_q};
            a_d    = bus.dh;
            b_d    = bus.dl;
            op_d   = bus.op;
            case (bus.op)
                OpMthi: hi_d = bus.dh;
                OpMtlo: lo_d = bus.dh;
                OpDiv, OpDivu: begin
                    state_d = StDiv;
                    cnt_d   = CntW'(DIV_CYCLES);
                end
                default: begin
                    state_d = StMul;
                    cnt_d   = CntW'(MUL_CYCLES);
                end
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            snap_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OpNop;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            snap_q    <= snap_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            invalid_q <= invalid_d;
        end
    end

    assign bus.busy    = busy;
    assign bus.invalid = invalid_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;

endmodule
